// File: rtl/du_pkg.sv
// Shared definitions for the debug-unit data-memory dump engine:
// one-hot state encodings, width derivations and memory read constants.
package du_pkg;

    localparam int NB_STATE = 9;

    localparam logic [NB_STATE-1:0] ST_IDLE      = 9'b0_0000_0001;
    localparam logic [NB_STATE-1:0] ST_RX_ADDR   = 9'b0_0000_0010;
    localparam logic [NB_STATE-1:0] ST_RX_COUNT  = 9'b0_0000_0100;
    localparam logic [NB_STATE-1:0] ST_READ      = 9'b0_0000_1000;
    localparam logic [NB_STATE-1:0] ST_WAIT      = 9'b0_0001_0000;
    localparam logic [NB_STATE-1:0] ST_SEND      = 9'b0_0010_0000;
    localparam logic [NB_STATE-1:0] ST_SEND_WAIT = 9'b0_0100_0000;
    localparam logic [NB_STATE-1:0] ST_NAK       = 9'b0_1000_0000;
    localparam logic [NB_STATE-1:0] ST_NAK_WAIT  = 9'b1_0000_0000;

    localparam logic [1:0] DMEM_RSIZE_WORD = 2'b11;

    // The terminating address is the all-ones word, whatever its width.
    localparam logic SENTINEL_FILL = 1'b1;

    function automatic int nb_bytes(input int nb_word, input int nb_uart);
        return nb_word / nb_uart;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/du_byte_deser.sv
// LSB-first byte deserialiser: holds the assembled word, counts received
// bytes and flags the byte that completes the word.
module du_byte_deser
    import du_pkg::*;
#(
    parameter int NB_UART_DATA = 8,
    parameter int NB_BYTES     = 4
) (
    input  logic                             clk,
    input  logic                             i_rst,
    input  logic                             clr,
    input  logic                             shift,
    input  logic [NB_UART_DATA-1:0]          byte_in,
    input  logic                             load,
    input  logic [NB_BYTES*NB_UART_DATA-1:0] load_value,
    output logic [NB_BYTES*NB_UART_DATA-1:0] value,
    output logic [NB_BYTES*NB_UART_DATA-1:0] value_nxt,
    output logic                             done
);

    localparam int W     = NB_BYTES * NB_UART_DATA;
    localparam int CNT_W = cnt_width(NB_BYTES);

    logic [CNT_W-1:0] cnt;

    // New byte enters at the MSB side so the first byte ends up in the LSBs.
    assign value_nxt = W'({byte_in, value} >> NB_UART_DATA);
    assign done      = shift && (cnt == CNT_W'(NB_BYTES - 1));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            value <= '0;
            cnt   <= '0;
        end else begin
            if (shift) begin
                value <= value_nxt;
                cnt   <= done ? '0 : cnt + CNT_W'(1);
            end else if (load) begin
                value <= load_value;
            end
            if (clr) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/du_dmem_burst_tx.sv
// Debug-unit data-memory dump engine: receives start address and word count
// over UART, then streams that many consecutive memory words LSB byte first.
module du_dmem_burst_tx
    import du_pkg::*;
#(
    parameter int                      NB_DATA      = 32,
    parameter int                      NB_UART_DATA = 8,
    parameter int                      NB_COUNT     = 16,
    parameter int                      RD_LATENCY   = 4,
    parameter logic [NB_UART_DATA-1:0] NAK_BYTE     = 8'hEE
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_rx_done,
    input  logic [NB_UART_DATA-1:0] i_rx_data,
    input  logic                    i_tx_done,
    input  logic [NB_DATA-1:0]      i_dmem_data,
    output logic                    o_rd,
    output logic                    o_wr,
    output logic                    o_tx_start,
    output logic [NB_UART_DATA-1:0] o_wdata,
    output logic                    o_dmem_rd,
    output logic [1:0]              o_dmem_rsize,
    output logic [NB_DATA-1:0]      o_dmem_raddr,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int NB_BYTES  = nb_bytes(NB_DATA, NB_UART_DATA);
    localparam int NB_CBYTES = nb_bytes(NB_COUNT, NB_UART_DATA);
    localparam int IDX_W     = cnt_width(NB_BYTES);
    localparam int LAT_W     = cnt_width(RD_LATENCY);

    localparam logic [NB_DATA-1:0] ADDR_STEP  = NB_DATA'(NB_BYTES);
    localparam logic [NB_DATA-1:0] ALIGN_MASK = NB_DATA'(NB_BYTES - 1);

    logic [NB_STATE-1:0] state;
    logic [IDX_W-1:0]    idx;
    logic [LAT_W-1:0]    lat;
    logic [NB_DATA-1:0]  data;

    logic                addr_shift, addr_done;
    logic [NB_DATA-1:0]  addr, addr_nxt;
    logic                cnt_shift, cnt_done;
    logic [NB_COUNT-1:0] count, count_nxt;
    logic                word_done, sentinel, misaligned;

    assign addr_shift = (state == ST_RX_ADDR) && i_rx_done;
    assign cnt_shift  = (state == ST_RX_COUNT) && i_rx_done;
    assign word_done  = (state == ST_SEND_WAIT) && i_tx_done && (idx == IDX_W'(NB_BYTES - 1));
    assign sentinel   = (addr_nxt == {NB_DATA{SENTINEL_FILL}});
    assign misaligned = ((addr_nxt & ALIGN_MASK) != '0);

    du_byte_deser #(
        .NB_UART_DATA (NB_UART_DATA),
        .NB_BYTES     (NB_BYTES)
    ) u_addr_deser (
        .clk        (clk),
        .i_rst      (i_rst),
        .clr        (state == ST_IDLE),
        .shift      (addr_shift),
        .byte_in    (i_rx_data),
        .load       (word_done),
        .load_value (addr + ADDR_STEP),
        .value      (addr),
        .value_nxt  (addr_nxt),
        .done       (addr_done)
    );

    du_byte_deser #(
        .NB_UART_DATA (NB_UART_DATA),
        .NB_BYTES     (NB_CBYTES)
    ) u_count_deser (
        .clk        (clk),
        .i_rst      (i_rst),
        .clr        (state == ST_IDLE),
        .shift      (cnt_shift),
        .byte_in    (i_rx_data),
        .load       (word_done),
        .load_value (count - NB_COUNT'(1)),
        .value      (count),
        .value_nxt  (count_nxt),
        .done       (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            lat   <= '0;
            data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_RX_ADDR;
                        idx   <= '0;
                    end
                end
                ST_RX_ADDR: begin
                    if (addr_done) begin
                        if (sentinel)        state <= ST_IDLE;
                        else if (misaligned) state <= ST_NAK;
                        else                 state <= ST_RX_COUNT;
                    end
                end
                ST_RX_COUNT: begin
                    if (cnt_done) begin
                        state <= (count_nxt == '0) ? ST_RX_ADDR : ST_READ;
                    end
                end
                ST_READ: begin
                    lat   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Capture lands exactly RD_LATENCY cycles after the strobe cycle.
                    if (lat == LAT_W'(RD_LATENCY - 1)) begin
                        data  <= i_dmem_data;
                        idx   <= '0;
                        state <= ST_SEND;
                    end else begin
                        lat <= lat + LAT_W'(1);
                    end
                end
                ST_SEND: begin
                    state <= ST_SEND_WAIT;
                end
                ST_SEND_WAIT: begin
                    if (i_tx_done) begin
                        if (!word_done) begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_SEND;
                        end else begin
                            state <= (count == NB_COUNT'(1)) ? ST_RX_ADDR : ST_READ;
                        end
                    end
                end
                ST_NAK: begin
                    state <= ST_NAK_WAIT;
                end
                ST_NAK_WAIT: begin
                    if (i_tx_done) state <= ST_RX_ADDR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so an abort emits nothing in the reset cycle itself.
    always_comb begin
        o_rd         = 1'b0;
        o_wr         = 1'b0;
        o_tx_start   = 1'b0;
        o_wdata      = '0;
        o_dmem_rd    = 1'b0;
        o_dmem_rsize = '0;
        o_dmem_raddr = '0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        if (!i_rst) begin
            o_busy = (state != ST_IDLE);
            o_rd   = addr_shift || cnt_shift;
            o_done = addr_shift && addr_done && sentinel;
            case (state)
                ST_READ: begin
                    o_dmem_rd    = 1'b1;
                    o_dmem_rsize = DMEM_RSIZE_WORD;
                    o_dmem_raddr = addr;
                end
                ST_SEND: begin
                    o_wr       = 1'b1;
                    o_tx_start = 1'b1;
                    o_wdata    = data[int'(idx)*NB_UART_DATA +: NB_UART_DATA];
                end
                ST_NAK: begin
                    o_wr       = 1'b1;
                    o_tx_start = 1'b1;
                    o_wdata    = NAK_BYTE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_du_dmem_burst_tx.sv
// Directed self-checking bench for du_dmem_burst_tx: memory model with exact
// read latency, auto-responding UART Tx, and step-by-step host transactions.
module tb_du_dmem_burst_tx;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_rx_done = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_tx_done = 1'b0;
    logic [31:0] i_dmem_data;
    logic        o_rd, o_wr, o_tx_start, o_dmem_rd, o_busy, o_done;
    logic [7:0]  o_wdata;
    logic [1:0]  o_dmem_rsize;
    logic [31:0] o_dmem_raddr;

    du_dmem_burst_tx #(
        .NB_DATA      (32),
        .NB_UART_DATA (8),
        .NB_COUNT     (16),
        .RD_LATENCY   (LAT),
        .NAK_BYTE     (8'hEE)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_tx_done    (i_tx_done),
        .i_dmem_data  (i_dmem_data),
        .o_rd         (o_rd),
        .o_wr         (o_wr),
        .o_tx_start   (o_tx_start),
        .o_wdata      (o_wdata),
        .o_dmem_rd    (o_dmem_rd),
        .o_dmem_rsize (o_dmem_rsize),
        .o_dmem_raddr (o_dmem_raddr),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int cyc = 0;
    int tx_budget = -1;
    int done_cnt = 0;
    int dmem_viol = 0;
    bit mon_on = 1'b0;

    logic [7:0]  tx_q[$];
    int          tx_cyc[$];
    logic [31:0] rd_q[$];
    int          rd_cyc[$];
    int          txdone_cyc[$];
    logic [7:0]  eb[$];
    logic [31:0] ea[$];

    logic        pv [0:LAT];
    logic [31:0] pa [0:LAT];

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'hA1B2C3D4;
            32'h0000_0020: return 32'h11223344;
            32'h0000_0024: return 32'h55667788;
            32'h0000_0028: return 32'h99AABBCC;
            32'hFFFF_FFF8: return 32'hCAFEBABE;
            32'hFFFF_FFFC: return 32'h0BADF00D;
            32'h0000_0000: return 32'h12345678;
            default:       return 32'hDEADBEEF;
        endcase
    endfunction

    // Data is only valid on the one edge LAT cycles after the strobe cycle.
    assign i_dmem_data = pv[LAT] ? mem(pa[LAT]) : 32'hBAD0BAD0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pv[0] <= o_dmem_rd;
        pa[0] <= o_dmem_raddr;
        for (int k = 1; k <= LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
        if (mon_on) begin
            if (o_wr) begin
                tx_q.push_back(o_wdata);
                tx_cyc.push_back(cyc);
            end
            if (o_dmem_rd) begin
                rd_q.push_back(o_dmem_raddr);
                rd_cyc.push_back(cyc);
            end
            if (o_done) done_cnt++;
            if (o_dmem_rd ? (o_dmem_rsize !== 2'b11)
                          : (o_dmem_rsize !== 2'b00 || o_dmem_raddr !== 32'h0))
                dmem_viol++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (mon_on && o_wr && tx_budget != 0) begin
                if (tx_budget > 0) tx_budget--;
                repeat (3) @(negedge clk);
                i_tx_done = 1'b1;
                txdone_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        tx_q.delete(); tx_cyc.delete(); rd_q.delete(); rd_cyc.delete();
        txdone_cyc.delete(); eb.delete(); ea.delete();
        done_cnt = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        i_rx_done = 1'b1;
        i_rx_data = b;
        #1;
        while (!o_rd && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rx_pop", {63'd0, o_rd}, 64'd1);
        @(posedge clk);
        #1;
        i_rx_done = 1'b0;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [15:0] c);
        for (int i = 0; i < 4; i++) push_byte(a[8*i +: 8]);
        for (int i = 0; i < 2; i++) push_byte(c[8*i +: 8]);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic verify(input string name);
        check({name, "_ntx"}, 64'(tx_q.size()), 64'(eb.size()));
        for (int i = 0; i < eb.size() && i < tx_q.size(); i++)
            check({name, "_txbyte"}, 64'(tx_q[i]), 64'(eb[i]));
        check({name, "_nrd"}, 64'(rd_q.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < rd_q.size(); i++)
            check({name, "_raddr"}, 64'(rd_q[i]), 64'(ea[i]));
    endtask

    task automatic start_session();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", {63'd0, o_busy}, 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {16'd0, o_rd, o_wr, o_tx_start, o_wdata, o_dmem_rd, o_dmem_rsize,
               o_dmem_raddr, o_busy, o_done}, 64'd0);
        i_rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check("idle_busy", {63'd0, o_busy}, 64'd0);

        // Single word
        start_session();
        clear_logs();
        push_req(32'h10, 16'd1);
        wait_tx(4);
        eb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        ea = '{32'h10};
        verify("single");
        check("single_busy", {63'd0, o_busy}, 64'd1);

        // Burst of three with latency / ordering timing
        clear_logs();
        push_req(32'h20, 16'd3);
        wait_tx(12);
        eb = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
               8'hCC, 8'hBB, 8'hAA, 8'h99};
        ea = '{32'h20, 32'h24, 32'h28};
        verify("burst");
        if (rd_cyc.size() == 3 && tx_cyc.size() == 12 && txdone_cyc.size() >= 8) begin
            check("burst_lat0", 64'(tx_cyc[0] - rd_cyc[0]), 64'(LAT + 1));
            check("burst_lat2", 64'(tx_cyc[8] - rd_cyc[2]), 64'(LAT + 1));
            check("burst_rd1_after_txdone4", 64'(rd_cyc[1] - txdone_cyc[3]), 64'd1);
            check("burst_rd2_after_txdone8", 64'(rd_cyc[2] - txdone_cyc[7]), 64'd1);
        end else begin
            check("burst_timing_logs", 64'(rd_cyc.size()), 64'd3);
        end

        // Unaligned address gets a single NAK byte
        clear_logs();
        for (int i = 0; i < 4; i++) push_byte(8'h13 >> (8 * i));
        wait_tx(1);
        eb = '{8'hEE};
        verify("nak");

        // Wrap around the top of the address space
        clear_logs();
        push_req(32'hFFFF_FFF8, 16'd2);
        wait_tx(8);
        eb = '{8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC};
        verify("wrap1");

        clear_logs();
        push_req(32'h100, 16'd0);
        repeat (20) @(negedge clk);
        verify("count0");

        clear_logs();
        push_req(32'hFFFF_FFFC, 16'd2);
        wait_tx(8);
        eb = '{8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'h78, 8'h56, 8'h34, 8'h12};
        ea = '{32'hFFFF_FFFC, 32'h0};
        verify("wrap2");

        // Sentinel terminates the session
        clear_logs();
        for (int i = 0; i < 4; i++) push_byte(8'hFF);
        check("sentinel_done_cnt", 64'(done_cnt), 64'd1);
        check("sentinel_idle", {62'd0, o_busy, o_done}, 64'd0);
        begin
            int pops = 0;
            @(negedge clk);
            i_rx_done = 1'b1;
            i_rx_data = 8'h55;
            for (int i = 0; i < 4; i++) begin
                #1;
                if (o_rd) pops++;
                @(negedge clk);
            end
            i_rx_done = 1'b0;
            check("sentinel_no_count_pop", 64'(pops), 64'd0);
        end
        check("sentinel_done_once", 64'(done_cnt), 64'd1);

        // Reset in SEND_WAIT after two bytes
        start_session();
        clear_logs();
        tx_budget = 2;
        push_req(32'h10, 16'd1);
        wait_tx(3);
        check("abort_ntx_before", 64'(tx_q.size()), 64'd3);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check("abort_outputs",
              {16'd0, o_rd, o_wr, o_tx_start, o_wdata, o_dmem_rd, o_dmem_rsize,
               o_dmem_raddr, o_busy, o_done}, 64'd0);
        i_rst = 1'b0;
        tx_budget = -1;
        repeat (10) @(negedge clk);
        check("abort_ntx_after", 64'(tx_q.size()), 64'd3);
        check("abort_idle", {63'd0, o_busy}, 64'd0);

        start_session();
        clear_logs();
        push_req(32'h10, 16'd1);
        wait_tx(4);
        eb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        ea = '{32'h10};
        verify("fresh");

        check("dmem_port_rules", 64'(dmem_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
